// File: rtl/mdu_sequencer.sv
// mdu_sequencer -- iterative RV32M multiply/divide unit.
//
// Accepts one request at a time, runs a 32-step shift-add multiply or
// restoring divide on operand magnitudes, fixes the sign at the end, and
// holds the result until the consumer takes it.
//
// Timing: the cycle after the accept edge is cycle 1. Iterative ops are busy
// in cycles 1..32 and present out_valid from cycle 33. Divide-by-zero,
// signed overflow and (without divide support) any divide op present
// out_valid from cycle 1.
//
// Handshakes: a request transfers on a rising edge where in_valid & in_ready.
// A result transfers on a rising edge where out_valid & out_ready.
// out_valid, result and op_illegal stay stable until that transfer.
//
// Configuration: define MDU_DIV_EN to compile in the divide datapath. When it
// is undefined, divide ops complete at once with result 0 and op_illegal 1.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake
//   funct3               RV32M op select
//   src_a, src_b         rs1 / rs2 operands, latched on accept
//   flush                abort any operation, return to IDLE
//   busy                 high in every state except IDLE
//   out_valid/out_ready  result handshake
//   result, op_illegal   outputs, forced to 0 while out_valid is low
//   dbg_state            current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        op_illegal,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] opnd_q, opnd_d;     // multiplicand magnitude or divisor magnitude
    logic [63:0] acc_q, acc_d;       // {partial product, multiplier} or {remainder, quotient}
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    logic        accept;
    logic        a_signed, b_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_prod;
    logic [31:0] mul_result;

    assign in_ready   = (state_q == IDLE) & ~flush;
    assign accept     = in_valid & in_ready;
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = out_valid ? result_q : 32'd0;
    assign op_illegal = out_valid & illegal_q;
    assign dbg_state  = state_q;

    // Which operands are treated as two's complement for this op.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001: begin a_signed = 1'b1; b_signed = 1'b1; end // MULH
            3'b010: begin a_signed = 1'b1; b_signed = 1'b0; end // MULHSU
            3'b100: begin a_signed = 1'b1; b_signed = 1'b1; end // DIV
            3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end // REM
            default: begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
    end

    assign mag_a = (a_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign mag_b = (b_signed & src_b[31]) ? (32'd0 - src_b) : src_b;

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    assign mul_sum    = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    assign mul_next   = {mul_sum, acc_q[31:1]};
    assign mul_prod   = (neg_a_q ^ neg_b_q) ? (64'd0 - mul_next) : mul_next;
    // MUL takes the low word; only MUL has op 000, its sign flags are clear.
    assign mul_result = (op_q == 3'b000) ? mul_prod[31:0] : mul_prod[63:32];

`ifdef MDU_DIV_EN
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] div_q, div_r, div_result;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor only when it fits.
    assign div_sh     = {acc_q[63:32], acc_q[31]};
    assign div_ge     = (div_sh >= {1'b0, opnd_q});
    assign div_diff   = div_sh[31:0] - opnd_q;
    assign div_next   = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                               : {div_sh[31:0], acc_q[30:0], 1'b0};
    assign div_q      = div_next[31:0];
    assign div_r      = div_next[63:32];
    assign div_result = op_q[1] ? (neg_a_q ? (32'd0 - div_r) : div_r)
                                : ((neg_a_q ^ neg_b_q) ? (32'd0 - div_q) : div_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        result_d  = result_q;
        illegal_d = illegal_q;

        if (flush) begin
            state_d   = IDLE;
            cnt_d     = 5'd0;
            result_d  = 32'd0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d      = funct3;
                        neg_a_d   = a_signed & src_a[31];
                        neg_b_d   = b_signed & src_b[31];
                        cnt_d     = 5'd0;
                        result_d  = 32'd0;
                        illegal_d = 1'b0;
                        if (!funct3[2]) begin
                            state_d = MUL;
                            opnd_d  = mag_a;
                            acc_d   = {32'd0, mag_b};
                        end else begin
`ifdef MDU_DIV_EN
                            if (src_b == 32'd0) begin
                                state_d  = DONE;
                                result_d = funct3[1] ? src_a : 32'hFFFF_FFFF;
                            end else if (!funct3[0] && (src_a == 32'h8000_0000) &&
                                         (src_b == 32'hFFFF_FFFF)) begin
                                state_d  = DONE;
                                result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                            end else begin
                                state_d = DIV;
                                opnd_d  = mag_b;
                                acc_d   = {32'd0, mag_a};
                            end
`else
                            state_d   = DONE;
                            result_d  = 32'd0;
                            illegal_d = 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        result_d = mul_result;
                    end
                end
                DIV: begin
`ifdef MDU_DIV_EN
                    acc_d = div_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        result_d = div_result;
                    end
`else
                    state_d = IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state_d   = IDLE;
                        result_d  = 32'd0;
                        illegal_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            result_q  <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer -- self-checking bench for mdu_sequencer.
//
// Handshakes: a request transfers on a rising edge with in_valid & in_ready;
// a result transfers on a rising edge with out_valid & out_ready.
// Latency is counted with the cycle after the accept edge as cycle 1.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        op_illegal;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  // Scoreboard: one entry per tracked request, in issue order.
  logic [31:0] exp_q[$];
  logic        exp_ill_q[$];
  int          exp_lat_q[$];
  int          acc_edge_q[$];

  mdu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .op_illegal (op_illegal),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {op_illegal, result}; lat is the cycle on which out_valid appears.
  function automatic logic [32:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    logic        ill;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    lat = 33;
    ill = 1'b0;
    r   = 32'd0;
    p   = 64'd0;
    case (f3)
      3'b000: begin p = ua * ub; r = p[31:0];  end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      default: begin
`ifdef MDU_DIV_EN
        if (b == 32'd0) begin
          lat = 1;
          r   = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 1;
          r   = f3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
          case (f3)
            3'b100:  p = 64'($signed(sa) / $signed(sb));
            3'b101:  p = ua / ub;
            3'b110:  p = 64'($signed(sa) % $signed(sb));
            default: p = ua % ub;
          endcase
          r = p[31:0];
        end
`else
        lat = 1;
        ill = 1'b1;
        r   = 32'd0;
`endif
      end
    endcase
    return {ill, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    int n;
    int lat;
    logic [32:0] m;
    in_valid = 1'b1;
    funct3   = f3;
    src_a    = a;
    src_b    = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got %b expected 1", in_ready);
    end else begin
      last_acc = cyc + 1;
      if (track) begin
        m = model(f3, a, b, lat);
        exp_q.push_back(m[31:0]);
        exp_ill_q.push_back(m[32]);
        exp_lat_q.push_back(lat);
        acc_edge_q.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    // Scramble the inputs so a design that fails to latch them shows it.
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  // Let the current operation finish; rnd throttles out_ready randomly.
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      n++;
    end while (busy && n < 300);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy got 1 expected 0");
    end
    out_ready = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          seen = 1'b0;
  logic [31:0] held_r;
  logic        held_i;
  logic [31:0] er;
  logic        ei;
  int          el, ae;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (!out_valid) begin
      chk("idle_result", result, 32'd0);
      chk("idle_illegal", 32'(op_illegal), 32'd0);
    end else begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: result %h with no pending request", result);
        end else begin
          er = exp_q.pop_front();
          ei = exp_ill_q.pop_front();
          el = exp_lat_q.pop_front();
          ae = acc_edge_q.pop_front();
          chk("result", result, er);
          chk("op_illegal", 32'(op_illegal), 32'(ei));
          chk("latency", 32'(cyc - ae + 1), 32'(el));
        end
        seen   = 1'b1;
        held_r = result;
        held_i = op_illegal;
      end else begin
        chk("hold_result", result, held_r);
        chk("hold_illegal", 32'(op_illegal), 32'(held_i));
      end
      chk("done_in_ready", 32'(in_ready), 32'd0);
      if (out_ready) seen = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0]  rf;
  logic [31:0] ra, rb;
  int          flush_edge;

  initial begin
    // Reset state.
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", 32'(op_illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MUL 7 x -6: busy through cycles 1..33, then result held 5+ cycles.
    out_ready = 1'b0;
    issue(3'b000, 32'd7, 32'hFFFF_FFFA, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("mul_busy", 32'(busy), 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_ready", 32'(busy), 32'd0);
    chk("in_ready_after_ready", 32'(in_ready), 32'd1);

    // Directed corner vectors.
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain(1'b0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain(1'b0);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain(1'b0);
    issue(3'b100, 32'hFFFF_FFEC, 32'd3, 1'b1);          drain(1'b0);
    issue(3'b110, 32'hFFFF_FFEC, 32'd3, 1'b1);          drain(1'b0);
    issue(3'b101, 32'd5, 32'd0, 1'b1);                  drain(1'b0);
    issue(3'b111, 32'd7, 32'd0, 1'b1);                  drain(1'b0);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  drain(1'b0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  drain(1'b0);
    issue(3'b101, 32'd9, 32'd3, 1'b1);                  drain(1'b0);

    // Flush at cycle 10 of a multiply; a new MUL is accepted right after.
    out_ready = 1'b1;
    issue(3'b000, $urandom, $urandom, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    flush_edge = cyc;
    chk("flush_busy", 32'(busy), 32'd0);
    issue(3'b000, 32'd12345, 32'd678, 1'b1);
    chk("accept_after_flush", 32'(last_acc), 32'(flush_edge + 1));
    drain(1'b0);

    // Flush in IDLE with a request waiting accepts nothing.
    in_valid = 1'b1;
    funct3   = 3'b000;
    flush    = 1'b1;
    @(negedge clk);
    chk("idle_flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply.
    issue(3'b001, $urandom, $urandom, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    chk("rst_release_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random out_ready back-pressure.
    for (int i = 0; i < 48; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 100)); rb = 32'($urandom_range(1, 9)); end
        default: ;
      endcase
      issue(rf, ra, rb, 1'b1);
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
